// File: rtl/z_scan_sched_if.sv
// Bundle of requester, engine and forwarded-stream signals for z_scan_sched.
// The scheduler takes the slave side; requesters/engine drive the master side.
interface z_scan_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            err;
  logic            busy;
  logic            sob;
  logic [5:0]      zid;
  logic            zid_vld;
  logic [5:0]      out_zid;
  logic            out_vld;
  logic [IDW-1:0]  out_id;

  modport master (
    output req, zid, zid_vld,
    input  gnt, done, err, busy, sob, out_zid, out_vld, out_id
  );

  modport slave (
    input  req, zid, zid_vld,
    output gnt, done, err, busy, sob, out_zid, out_vld, out_id
  );
endinterface

// File: rtl/z_scan_sched.sv
// Round-robin owner of a shared z_scan engine: grants, starts, forwards 64
// tagged indices, signals done per requester and aborts stalled scans.
module z_scan_sched #(
  parameter int NREQ = 4,
  parameter int TMO  = 16,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic           clk,
  input logic           rst,
  z_scan_sched_if.slave bus
);

  localparam int TW = $clog2(TMO);

  typedef enum logic [1:0] {IDLE, START, SCAN, DONE} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] owner;
  logic [5:0]     cnt;
  logic [TW-1:0]  tmr;

  logic           pick_vld;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] nxt_ptr;
  logic [IDW-1:0] idx;

  // Walk downward so the candidate closest to ptr is the last one written.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (bus.req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
    nxt_ptr = (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + IDW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      cnt         <= '0;
      tmr         <= '0;
      bus.gnt     <= '0;
      bus.done    <= '0;
      bus.err     <= 1'b0;
      bus.busy    <= 1'b0;
      bus.sob     <= 1'b0;
      bus.out_zid <= '0;
      bus.out_vld <= 1'b0;
      bus.out_id  <= '0;
    end else begin
      bus.sob     <= 1'b0;
      bus.done    <= '0;
      bus.err     <= 1'b0;
      bus.out_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            bus.gnt  <= NREQ'(1) << pick_id;
            owner    <= pick_id;
            ptr      <= nxt_ptr;
            bus.busy <= 1'b1;
            bus.sob  <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          cnt   <= '0;
          tmr   <= '0;
          state <= SCAN;
        end
        SCAN: begin
          if (bus.zid_vld) begin
            bus.out_vld <= 1'b1;
            bus.out_zid <= bus.zid;
            bus.out_id  <= owner;
            cnt         <= cnt + 6'd1;
            tmr         <= '0;
            if (cnt == 6'd63) begin
              bus.done <= NREQ'(1) << owner;
              state    <= DONE;
            end
          end else if (tmr == TW'(TMO - 1)) begin
            // Stalled engine: release the grant without a done.
            bus.err  <= 1'b1;
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        DONE: begin
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z_scan_sched.sv
// Self-checking bench for z_scan_sched: edge-indexed behavioural model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_z_scan_sched;

  localparam int NREQ = 4;
  localparam int TMO  = 16;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;

  z_scan_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  z_scan_sched #(.NREQ(NREQ), .TMO(TMO), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: edge counter plus the edge numbers at which each block started,
  // last saw an index, and finished.
  int m_edge, m_own, m_ptr, m_gedge, m_ref, m_nidx, m_fin, m_arb;
  logic [NREQ-1:0] x_gnt, x_done;
  logic            x_err, x_busy, x_sob, x_vld;
  logic [5:0]      x_zid;
  logic [IDW-1:0]  x_id;

  int sob_cnt, vld_cnt, err_cnt;
  int done_cnt [NREQ];
  int glog [$];
  logic [NREQ-1:0] prev_gnt;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_gedge = 0; m_ref = 0; m_nidx = 0; m_fin = -1; m_arb = 0;
    x_gnt = '0; x_done = '0; x_err = 1'b0; x_busy = 1'b0; x_sob = 1'b0;
    x_vld = 1'b0; x_zid = '0; x_id = '0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic v, input logic [5:0] z);
    int pick;
    x_sob = 1'b0; x_done = '0; x_err = 1'b0; x_vld = 1'b0;
    if (m_own < 0) begin
      pick = -1;
      for (int i = 0; i < NREQ; i++)
        if (pick < 0 && r[(m_ptr + i) % NREQ]) pick = (m_ptr + i) % NREQ;
      if (m_edge >= m_arb && pick >= 0) begin
        m_own = pick; m_ptr = (pick + 1) % NREQ;
        m_gedge = m_edge; m_ref = m_edge + 1; m_nidx = 0; m_fin = -1;
        x_gnt = NREQ'(1) << pick; x_busy = 1'b1; x_sob = 1'b1;
      end
    end else if (m_fin >= 0) begin
      x_gnt = '0; x_busy = 1'b0; m_own = -1; m_arb = m_edge + 1;
    end else if (m_edge >= m_gedge + 2) begin
      if (v) begin
        x_vld = 1'b1; x_zid = z; x_id = IDW'(m_own);
        m_nidx++; m_ref = m_edge;
        if (m_nidx == 64) begin
          m_fin = m_edge; x_done = NREQ'(1) << m_own;
        end
      end else if (m_edge - m_ref == TMO) begin
        x_err = 1'b1; x_gnt = '0; x_busy = 1'b0; m_own = -1; m_arb = m_edge + 1;
      end
    end
  endtask

  initial begin
    m_edge = 0;
    model_reset();
    prev_gnt = '0;
    forever begin
      @(posedge clk);
      m_edge++;
      if (rst) model_reset();
      else model_step(bus.req, bus.zid_vld, bus.zid);
      @(negedge clk);
      if (rst) model_reset();
      check_output("cyc_gnt",     bus.gnt,     x_gnt);
      check_output("cyc_done",    bus.done,    x_done);
      check_output("cyc_err",     bus.err,     x_err);
      check_output("cyc_busy",    bus.busy,    x_busy);
      check_output("cyc_sob",     bus.sob,     x_sob);
      check_output("cyc_out_vld", bus.out_vld, x_vld);
      check_output("cyc_out_zid", bus.out_zid, x_zid);
      check_output("cyc_out_id",  bus.out_id,  x_id);
      check_output("gnt_onehot",  ($countones(bus.gnt) <= 1), 1);
      if (bus.sob) sob_cnt++;
      if (bus.out_vld) vld_cnt++;
      if (bus.err) err_cnt++;
      for (int i = 0; i < NREQ; i++) if (bus.done[i]) done_cnt[i]++;
      if (prev_gnt == '0 && bus.gnt != '0) glog.push_back($clog2(bus.gnt));
      prev_gnt = bus.gnt;
    end
  end

  task automatic clear_monitors();
    sob_cnt = 0; vld_cnt = 0; err_cnt = 0;
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
    glog.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    bus.req = '0; bus.zid_vld = 1'b0; bus.zid = '0;
    @(negedge clk);
    clear_monitors();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_sob();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.sob) ok = 1'b1;
    end
    if (!ok) check_output("sob_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.gnt == '0) ok = 1'b1;
    end
    if (!ok) check_output("idle_timeout", 0, 1);
  endtask

  // gap_mode: 0 contiguous, 1 alternate cycles, 2 random gaps below the timeout.
  task automatic apply_stimulus(input int n, input int gap_mode, input bit ramp);
    int g;
    for (int i = 0; i < n; i++) begin
      bus.zid     = ramp ? 6'(i) : 6'($urandom_range(0, 63));
      bus.zid_vld = 1'b1;
      @(negedge clk);
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, TMO - 2) : 0;
      if (g > 0) begin
        bus.zid_vld = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
    bus.zid_vld = 1'b0;
  endtask

  initial begin
    int j;
    rst = 1'b1;
    bus.req = '0; bus.zid = '0; bus.zid_vld = 1'b0;
    clear_monitors();
    repeat (2) @(negedge clk);
    check_output("rst_gnt", bus.gnt, 0);
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_out_zid", bus.out_zid, 0);
    check_output("rst_out_id", bus.out_id, 0);
    rst = 1'b0;

    $display("[TB] single requester");
    do_reset();
    bus.req = 4'b0001;
    wait_sob();
    check_output("t1_gnt_start", bus.gnt, 4'b0001);
    @(negedge clk);
    apply_stimulus(64, 0, 1'b1);
    check_output("t1_last_vld", bus.out_vld, 1);
    check_output("t1_last_zid", bus.out_zid, 63);
    check_output("t1_done", bus.done, 4'b0001);
    check_output("t1_gnt_held", bus.gnt, 4'b0001);
    bus.req = '0;
    @(negedge clk);
    check_output("t1_gnt_low", bus.gnt, 0);
    check_output("t1_done_low", bus.done, 0);
    check_output("t1_sob_cnt", sob_cnt, 1);
    check_output("t1_vld_cnt", vld_cnt, 64);

    $display("[TB] all requesters");
    do_reset();
    bus.req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      wait_sob();
      if (b == 4) bus.req = '0;
      @(negedge clk);
      apply_stimulus(64, 0, 1'b0);
      wait_idle();
    end
    check_output("t2_glog_size", glog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < glog.size()) check_output("t2_order", glog[i], i % NREQ);
    check_output("t2_done0", done_cnt[0], 2);
    check_output("t2_done1", done_cnt[1], 1);
    check_output("t2_done3", done_cnt[3], 1);

    $display("[TB] gappy engine");
    do_reset();
    bus.req = 4'b0001;
    wait_sob();
    bus.req = '0;
    @(negedge clk);
    apply_stimulus(64, 1, 1'b0);
    wait_idle();
    check_output("t3_err_cnt", err_cnt, 0);
    check_output("t3_done0", done_cnt[0], 1);
    check_output("t3_vld_cnt", vld_cnt, 64);

    $display("[TB] stall");
    do_reset();
    bus.req = 4'b0011;
    wait_sob();
    @(negedge clk);
    apply_stimulus(10, 0, 1'b0);
    j = 1;
    while (!bus.err && j < 200) begin
      @(negedge clk);
      j++;
    end
    check_output("t4_err_delay", j, TMO + 1);
    check_output("t4_gnt_at_err", bus.gnt, 0);
    check_output("t4_busy_at_err", bus.busy, 0);
    bus.req = 4'b0010;
    wait_sob();
    check_output("t4_next_gnt", bus.gnt, 4'b0010);
    bus.req = '0;
    @(negedge clk);
    apply_stimulus(64, 0, 1'b0);
    wait_idle();
    check_output("t4_done0", done_cnt[0], 0);
    check_output("t4_done1", done_cnt[1], 1);

    $display("[TB] drop and spurious valid");
    do_reset();
    bus.zid_vld = 1'b1; bus.zid = 6'd17;
    repeat (3) @(negedge clk);
    bus.zid_vld = 1'b0;
    @(negedge clk);
    check_output("t5_stray_vld", vld_cnt, 0);
    bus.req = 4'b0010;
    wait_sob();
    bus.zid_vld = 1'b1; bus.zid = 6'd5;
    @(negedge clk);
    apply_stimulus(30, 0, 1'b0);
    bus.req = '0;
    apply_stimulus(34, 0, 1'b0);
    wait_idle();
    check_output("t5_done1", done_cnt[1], 1);
    check_output("t5_vld_cnt", vld_cnt, 64);

    $display("[TB] reset mid-scan");
    do_reset();
    bus.req = 4'b0100;
    wait_sob();
    @(negedge clk);
    apply_stimulus(30, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_output("t6_gnt", bus.gnt, 0);
    check_output("t6_busy", bus.busy, 0);
    check_output("t6_out_zid", bus.out_zid, 0);
    check_output("t6_out_vld", bus.out_vld, 0);
    check_output("t6_out_id", bus.out_id, 0);
    check_output("t6_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.req = 4'b0101;
    wait_sob();
    check_output("t6_first_gnt", bus.gnt, 4'b0001);
    bus.req = '0;
    @(negedge clk);
    apply_stimulus(64, 0, 1'b0);
    wait_idle();

    $display("[TB] random traffic");
    do_reset();
    for (int b = 0; b < 8; b++) begin
      bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      wait_sob();
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) apply_stimulus($urandom_range(0, 63), 2, 1'b0);
      else apply_stimulus(64, 2, 1'b0);
      wait_idle();
    end
    bus.req = '0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
